// File: rtl/nibble_packer.sv
// Packs a DATA_W-bit valid/ready beat stream into LANES-wide words with keep/last marking.
// Optional parity output when NIBBLE_PACKER_PARITY_EN is defined.
module nibble_packer #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned LANES  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic [DATA_W-1:0]         data_i,
  input  logic                      last_i,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic [DATA_W*LANES-1:0]   data_o,
  output logic [LANES-1:0]          keep_o,
  output logic                      last_o
`ifdef NIBBLE_PACKER_PARITY_EN
  ,
  output logic                      parity_o
`endif
);

  localparam int unsigned CntW  = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned AccW  = DATA_W * (LANES - 1);
  localparam int unsigned WordW = DATA_W * LANES;
  localparam logic [CntW-1:0] LastLane = CntW'(LANES - 1);

  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [AccW-1:0]  acc_q, acc_d;
  logic             out_full_q, out_full_d;
  logic [WordW-1:0] data_q, data_d;
  logic [LANES-1:0] keep_q, keep_d;
  logic             last_q, last_d;

  logic             accept;
  logic             closing;
  logic [WordW-1:0] acc_ext;
  logic [WordW-1:0] word;
  logic [LANES-1:0] word_keep;

  assign ready_o = ~rst & (~out_full_q | ready_i);
  assign accept  = valid_i & ready_o;
  assign closing = accept & ((cnt_q == LastLane) | last_i);

  // Top lane padded with zeros so every lane index is in range of the accumulator.
  assign acc_ext = {{DATA_W{1'b0}}, acc_q};

  always_comb begin
    word      = '0;
    word_keep = '0;
    for (int k = 0; k < LANES; k++) begin
      if (CntW'(k) < cnt_q) begin
        word[k*DATA_W +: DATA_W] = acc_ext[k*DATA_W +: DATA_W];
      end else if (CntW'(k) == cnt_q) begin
        word[k*DATA_W +: DATA_W] = data_i;
      end
      word_keep[k] = (CntW'(k) <= cnt_q);
    end
  end

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (accept) begin
      if (closing) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        for (int k = 0; k < LANES - 1; k++) begin
          if (CntW'(k) == cnt_q) begin
            acc_d[k*DATA_W +: DATA_W] = data_i;
          end
        end
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  // A closing beat reloads the output register even while the old word drains.
  always_comb begin
    out_full_d = out_full_q;
    data_d     = data_q;
    keep_d     = keep_q;
    last_d     = last_q;
    if (closing) begin
      out_full_d = 1'b1;
      data_d     = word;
      keep_d     = word_keep;
      last_d     = last_i;
    end else if (out_full_q && ready_i) begin
      out_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      acc_q      <= '0;
      out_full_q <= 1'b0;
      data_q     <= '0;
      keep_q     <= '0;
      last_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      out_full_q <= out_full_d;
      data_q     <= data_d;
      keep_q     <= keep_d;
      last_q     <= last_d;
    end
  end

  assign valid_o = out_full_q;
  assign data_o  = data_q;
  assign keep_o  = keep_q;
  assign last_o  = last_q;

`ifdef NIBBLE_PACKER_PARITY_EN
  logic parity_q, parity_d;

  // Lanes above the closing lane are already zero in word, so they add nothing.
  always_comb begin
    parity_d = parity_q;
    if (closing) begin
      parity_d = ^word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign parity_o = parity_q;
`endif

endmodule

// File: tb/tb_nibble_packer.sv
// Scoreboard bench for nibble_packer: directed beats push expected words, a monitor pops on handshake.
module tb_nibble_packer;

  logic        clk;
  logic        rst;
  logic        valid_i;
  logic        ready_o;
  logic [3:0]  data_i;
  logic        last_i;
  logic        valid_o;
  logic        ready_i;
  logic [15:0] data_o;
  logic [3:0]  keep_o;
  logic        last_o;
`ifdef NIBBLE_PACKER_PARITY_EN
  logic        parity_o;
`endif

  nibble_packer #(
    .DATA_W(4),
    .LANES (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  (data_i),
    .last_i  (last_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (data_o),
    .keep_o  (keep_o),
    .last_o  (last_o)
`ifdef NIBBLE_PACKER_PARITY_EN
    ,
    .parity_o(parity_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  keep;
    logic        last;
    logic        par;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   words_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] d, input logic [3:0] k, input logic l, input logic p);
    exp_t x;
    x.data = d;
    x.keep = k;
    x.last = l;
    x.par  = p;
    q.push_back(x);
  endtask

  // Presents one beat and returns #1 after the edge that accepted it.
  task automatic send(input logic [3:0] d, input logic l);
    int n;
    n       = 0;
    valid_i = 1'b1;
    data_i  = d;
    last_i  = l;
    @(negedge clk);
    while (!ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ready_o) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got ready_o=0 expected ready_o=1 for beat %0h", d);
    end
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    last_i  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && valid_o && ready_i) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %h expected no word", data_o);
      end else begin
        e = q.pop_front();
        words_seen++;
        check("word_data", 32'(data_o), 32'(e.data));
        check("word_keep", 32'(keep_o), 32'(e.keep));
        check("word_last", 32'(last_o), 32'(e.last));
`ifdef NIBBLE_PACKER_PARITY_EN
        check("word_parity", 32'(parity_o), 32'(e.par));
`endif
      end
    end
  end

  initial begin
    int n;
    rst     = 1'b1;
    valid_i = 1'b1;
    data_i  = 4'h0;
    last_i  = 1'b0;
    ready_i = 1'b1;

    // Reset with valid_i high
    repeat (3) @(negedge clk);
    check("rst_valid_o", 32'(valid_o), 32'h0);
    check("rst_data_o", 32'(data_o), 32'h0);
    check("rst_keep_o", 32'(keep_o), 32'h0);
    check("rst_last_o", 32'(last_o), 32'h0);
    check("rst_ready_o", 32'(ready_o), 32'h0);
    rst     = 1'b0;
    valid_i = 1'b0;
    @(negedge clk);
    check("post_rst_ready_o", 32'(ready_o), 32'h1);
    idle(1);

    // Full word
    push(16'h4321, 4'b1111, 1'b0, 1'b1);
    send(4'h1, 1'b0);
    send(4'h2, 1'b0);
    check("no_early_valid", 32'(valid_o), 32'h0);
    send(4'h3, 1'b0);
    send(4'h4, 1'b0);
    check("full_latency", 32'(valid_o), 32'h1);
    idle(2);

    // Partial word, next beat lands in lane 0
    push(16'h00BA, 4'b0011, 1'b1, 1'b1);
    send(4'hA, 1'b0);
    send(4'hB, 1'b1);
    push(16'h000C, 4'b0001, 1'b1, 1'b0);
    send(4'hC, 1'b1);
    idle(2);

    // Backpressure
    ready_i = 1'b0;
    push(16'h8765, 4'b1111, 1'b0, 1'b0);
    send(4'h5, 1'b0);
    send(4'h6, 1'b0);
    send(4'h7, 1'b0);
    send(4'h8, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_valid_o", 32'(valid_o), 32'h1);
      check("stall_data_o", 32'(data_o), 32'h8765);
      check("stall_ready_o", 32'(ready_o), 32'h0);
    end
    @(posedge clk);
    #1;
    ready_i = 1'b1;
    @(posedge clk);
    #1;
    check("drain_valid_o", 32'(valid_o), 32'h0);
    check("drain_ready_o", 32'(ready_o), 32'h1);
    idle(1);

    // Streaming 0..F, drain and close coincide
    push(16'h3210, 4'b1111, 1'b0, 1'b0);
    push(16'h7654, 4'b1111, 1'b0, 1'b0);
    push(16'hBA98, 4'b1111, 1'b0, 1'b0);
    push(16'hFEDC, 4'b1111, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      send(4'(i), 1'b0);
    end
    idle(2);

    // Reset mid-word discards the partial word
    send(4'h5, 1'b0);
    send(4'h6, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_valid_o", 32'(valid_o), 32'h0);
    check("midrst_data_o", 32'(data_o), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    idle(3);
    check("post_midrst_valid_o", 32'(valid_o), 32'h0);
    push(16'h4321, 4'b1111, 1'b0, 1'b1);
    send(4'h1, 1'b0);
    send(4'h2, 1'b0);
    send(4'h3, 1'b0);
    send(4'h4, 1'b0);

    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    idle(2);
    check("queue_drained", 32'(q.size()), 32'h0);
    check("word_count", 32'(words_seen), 32'd9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
